// File: rtl/mgmt_bus_initiator.sv
// mgmt_bus_initiator
// Initiator side of the management register bus. Takes host bytes from the
// QSPI byte front end, decodes a 2-byte header ({rw, addr[14:8]}, addr[7:0])
// and runs auto-incrementing burst writes or prefetched burst reads.
//
// Ports:
//   clk, rst                 core clock, async active-high reset
//   txn_start, txn_end       chip-select assert / deassert pulses
//   rx_valid, rx_data        received host byte
//   tx_valid, tx_data, tx_ack  staged read byte and its consume pulse
//   rd_en, rd_addr           register read strobe / address
//   rd_valid, rd_data        read response
//   wr_en, wr_addr, wr_data  register write strobe / address / data
//   busy                     FSM not idle
//   timeout_err              sticky read timeout, cleared by txn_start
module mgmt_bus_initiator #(
  parameter int READ_TIMEOUT = 255,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        txn_start,
  input  logic        txn_end,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ack,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD
  } state_e;

  // Last count value before giving up; the counter starts at 0 in the cycle
  // the rd_en pulse is on the bus.
  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = TIMEOUT_BITS'(READ_TIMEOUT - 1);

  state_e                  state_q;
  logic                    rw_q;
  logic [14:0]             addr_q;
  logic [14:0]             addr_d;
  logic [TIMEOUT_BITS-1:0] cnt_q;
  logic                    tx_valid_q;
  logic [7:0]              tx_data_q;
  logic                    rd_en_q;
  logic                    wr_en_q;
  logic [15:0]             wr_addr_q;
  logic [7:0]              wr_data_q;
  logic                    timeout_err_q;

  // 15-bit add wraps 0x7FFF -> 0x0000 by itself.
  assign addr_d = addr_q + 15'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // Strobes are single-cycle; a strobe already on the bus this cycle
      // completes regardless of an abort.
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      if (txn_start) begin
        // Start wins over a coincident end; any in-flight read is dropped.
        state_q       <= HDR_HI;
        tx_valid_q    <= 1'b0;
        timeout_err_q <= 1'b0;
      end else if (txn_end) begin
        state_q    <= IDLE;
        tx_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          HDR_HI: if (rx_valid) begin
            rw_q         <= rx_data[7];
            addr_q[14:8] <= rx_data[6:0];
            state_q      <= HDR_LO;
          end
          HDR_LO: if (rx_valid) begin
            addr_q[7:0] <= rx_data;
            state_q     <= rw_q ? RD_ISSUE : WRITE;
          end
          WRITE: if (rx_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {1'b0, addr_q};
            wr_data_q <= rx_data;
            addr_q    <= addr_d;
          end
          RD_ISSUE: begin
            rd_en_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= RD_WAIT;
          end
          // rd_en is high during the first RD_WAIT cycle, so a same-cycle
          // rd_valid lands here too.
          RD_WAIT: begin
            if (rd_valid) begin
              tx_data_q  <= rd_data;
              tx_valid_q <= 1'b1;
              state_q    <= RD_HOLD;
            end else if (cnt_q == TMO_LAST) begin
              tx_data_q     <= 8'h00;
              tx_valid_q    <= 1'b1;
              timeout_err_q <= 1'b1;
              state_q       <= RD_HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RD_HOLD: if (tx_ack) begin
            tx_valid_q <= 1'b0;
            addr_q     <= addr_d;
            state_q    <= RD_ISSUE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign rd_en       = rd_en_q;
  // addr only moves after tx_ack, so it is stable across the rd_en pulse.
  assign rd_addr     = {1'b0, addr_q};
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mgmt_bus_initiator.sv
// Bench for mgmt_bus_initiator: table of burst transactions plus hand
// sequences for timeout, abort, start/end collision and async reset.
module tb_mgmt_bus_initiator;
  logic        clk = 1'b0;
  logic        rst;
  logic        txn_start, txn_end, rx_valid, tx_ack, rd_valid;
  logic [7:0]  rx_data, rd_data;
  logic        tx_valid, rd_en, wr_en, busy, timeout_err;
  logic [7:0]  tx_data, wr_data;
  logic [15:0] rd_addr, wr_addr;

  mgmt_bus_initiator #(.READ_TIMEOUT(4), .TIMEOUT_BITS(8)) dut (
    .clk(clk), .rst(rst), .txn_start(txn_start), .txn_end(txn_end),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ack(tx_ack), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [23:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [7:0]  resp_q[$];
  int          resp_lat = 1;
  bit          resp_silent = 1'b0;

  typedef struct {
    logic [7:0]       hi, lo;
    int               n;
    int               lat;
    logic [15:0]      exp_a0;
    logic [3:0][7:0]  d;
  } vec_t;
  vec_t vecs[6];

  function automatic vec_t mk(logic [7:0] hi, logic [7:0] lo, int n, int lat,
                              logic [15:0] a0, logic [7:0] b0, logic [7:0] b1,
                              logic [7:0] b2, logic [7:0] b3);
    vec_t v;
    v.hi = hi; v.lo = lo; v.n = n; v.lat = lat; v.exp_a0 = a0;
    v.d[0] = b0; v.d[1] = b1; v.d[2] = b2; v.d[3] = b3;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm, input logic [63:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s: got %0h expected none", nm, act);
  endtask

  // Scoreboard monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (exp_wr_q.size() == 0) fail_evt("wr_unexpected", {wr_addr, wr_data});
        else chk("wr_addr_data", {wr_addr, wr_data}, exp_wr_q.pop_front());
      end
      if (rd_en) begin
        if (exp_rd_q.size() == 0) fail_evt("rd_unexpected", rd_addr);
        else chk("rd_addr", rd_addr, exp_rd_q.pop_front());
      end
      if (rd_en && wr_en) fail_evt("rd_wr_overlap", 1);
    end
  end

  // Responder: rd_valid resp_lat cycles after the rd_en cycle (0 = same cycle).
  initial begin
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      if (rd_en && !rst && !resp_silent) begin
        repeat (resp_lat) @(negedge clk);
        rd_valid = 1'b1;
        rd_data  = (resp_q.size() != 0) ? resp_q.pop_front() : 8'hEE;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    txn_start = 1'b1;
    @(negedge clk);
    txn_start = 1'b0;
  endtask

  task automatic pulse_end();
    txn_end = 1'b1;
    @(negedge clk);
    txn_end = 1'b0;
  endtask

  task automatic wait_rd_en(input string nm);
    int t = 0;
    while (!rd_en && t < 20) begin @(negedge clk); t++; end
    if (!rd_en) fail_evt(nm, t);
  endtask

  task automatic consume(input string nm, input logic [7:0] exp_b);
    int t = 0;
    while (!tx_valid && t < 30) begin @(negedge clk); t++; end
    if (!tx_valid) fail_evt({nm, "_tx_timeout"}, t);
    else begin
      chk(nm, tx_data, exp_b);
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      chk("tx_drop_after_ack", tx_valid, 0);
    end
  endtask

  task automatic write_txn(input vec_t v);
    pulse_start();
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < v.n; i++)
      exp_wr_q.push_back({16'(v.exp_a0 + 16'(i)) & 16'h7FFF, v.d[i]});
    send(v.hi);
    send(v.lo);
    for (int i = 0; i < v.n; i++) send(v.d[i]);
    repeat (3) @(negedge clk);
    chk("wr_all_seen", exp_wr_q.size(), 0);
    pulse_end();
    chk("busy_after_end", busy, 0);
  endtask

  task automatic read_txn(input vec_t v);
    resp_lat = v.lat;
    pulse_start();
    chk("busy_after_start", busy, 1);
    for (int i = 0; i <= v.n; i++)
      exp_rd_q.push_back(16'(v.exp_a0 + 16'(i)) & 16'h7FFF);
    for (int i = 0; i < v.n; i++) resp_q.push_back(v.d[i]);
    resp_q.push_back(8'hEE);
    send(v.hi);
    send(v.lo);
    send(8'hA5);  // dummy host byte, must not cause a write
    for (int i = 0; i < v.n; i++) consume("tx_data", v.d[i]);
    repeat (8) @(negedge clk);
    chk("rd_all_seen", exp_rd_q.size(), 0);
    chk("prefetch_staged", {tx_valid, tx_data}, {1'b1, 8'hEE});
    pulse_end();
    chk("end_clears_tx", {busy, tx_valid}, 0);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1;
    txn_start = 0; txn_end = 0; rx_valid = 0; rx_data = 0; tx_ack = 0;
    #3;
    chk("reset_outputs", {tx_valid, tx_data, rd_en, rd_addr, wr_en, wr_addr,
                          wr_data, busy, timeout_err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = mk(8'h00, 8'h48, 3, 1, 16'h0048, 8'hAA, 8'h55, 8'h21, 8'h00);
    vecs[1] = mk(8'h80, 8'h00, 2, 3, 16'h0000, 8'h12, 8'h34, 8'h00, 8'h00);
    vecs[2] = mk(8'hFF, 8'hFF, 1, 0, 16'h7FFF, 8'h5A, 8'h00, 8'h00, 8'h00);
    vecs[3] = mk(8'h7F, 8'hFE, 3, 1, 16'h7FFE, 8'h01, 8'h02, 8'h03, 8'h00);
    vecs[4] = mk(8'h92, 8'h34, 3, 1, 16'h1234, 8'hC3, 8'h3C, 8'h77, 8'h00);
    vecs[5] = mk(8'h05, 8'h00, 4, 2, 16'h0500, 8'hDE, 8'hAD, 8'hBE, 8'hEF);

    foreach (vecs[i]) begin
      if (vecs[i].hi[7]) read_txn(vecs[i]);
      else write_txn(vecs[i]);
    end

    // Timeout: silent responder, READ_TIMEOUT=4.
    resp_silent = 1'b1;
    pulse_start();
    exp_rd_q.push_back(16'h0010);
    send(8'h80);
    send(8'h10);
    wait_rd_en("tmo_rd_en_missing");
    cyc = 0;
    while (!tx_valid && cyc < 10) begin @(negedge clk); cyc++; end
    chk("tmo_tx_valid_within_6", (tx_valid && cyc <= 6), 1);
    chk("tmo_tx_data", tx_data, 8'h00);
    chk("tmo_err_set", timeout_err, 1);
    pulse_end();
    chk("tmo_err_sticky", {timeout_err, tx_valid}, 2'b10);
    resp_silent = 1'b0;
    pulse_start();
    chk("tmo_err_cleared", timeout_err, 0);
    pulse_end();

    // Abort in RD_WAIT, late rd_valid must be ignored.
    resp_lat = 3;
    pulse_start();
    exp_rd_q.push_back(16'h0020);
    resp_q.push_back(8'h99);
    send(8'h80);
    send(8'h20);
    wait_rd_en("abort_rd_en_missing");
    pulse_end();
    chk("abort_idle", busy, 0);
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (tx_valid) seen = 1'b1; end
    chk("abort_no_tx", seen, 0);
    chk("abort_late_resp_sent", resp_q.size(), 0);

    // txn_start and txn_end together mid-write: start wins.
    pulse_start();
    send(8'h00);
    send(8'h00);
    txn_start = 1'b1; txn_end = 1'b1;
    @(negedge clk);
    txn_start = 1'b0; txn_end = 1'b0;
    chk("start_wins_busy", busy, 1);
    exp_wr_q.push_back({16'h0100, 8'h5C});
    send(8'h01);
    send(8'h00);
    send(8'h5C);
    repeat (2) @(negedge clk);
    chk("start_wins_wr", exp_wr_q.size(), 0);
    pulse_end();

    // Async reset while holding a staged byte.
    resp_lat = 1;
    pulse_start();
    exp_rd_q.push_back(16'h0030);
    resp_q.push_back(8'h3C);
    send(8'h80);
    send(8'h30);
    cyc = 0;
    while (!tx_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("hold_before_reset", {tx_valid, tx_data}, {1'b1, 8'h3C});
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {tx_valid, tx_data, rd_en, rd_addr, wr_en,
                                   wr_addr, wr_data, busy, timeout_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("queues_drained", {exp_wr_q.size(), exp_rd_q.size()}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mgmt_bus_initiator.md
Name: mgmt_bus_initiator

Overview:
Initiator side of the management register bus (16-bit address, 8-bit data, rd_en/rd_valid and wr_en strobes). It sits between the QSPI byte-level device front end and the management register block. It parses a 2-byte command header and then runs auto-incrementing burst reads or writes. Read data is prefetched so one byte is always staged for the host.

Parameters:
READ_TIMEOUT, 255, clk cycles to wait for rd_valid before substituting 0x00 and flagging an error
TIMEOUT_BITS, 8, width of the timeout counter; must hold READ_TIMEOUT

Ports:
clk  in  1  management core clock
rst  in  1  reset, asynchronous, active-high
txn_start  in  1  one-cycle pulse: chip select asserted, new transaction begins
txn_end  in  1  one-cycle pulse: chip select deasserted
rx_valid  in  1  one-cycle pulse: rx_data holds a byte from the host
rx_data  in  8  received byte
tx_valid  out  1  tx_data holds a staged read byte
tx_data  out  8  staged read byte
tx_ack  in  1  one-cycle pulse: front end consumed tx_data
rd_en  out  1  register read strobe
rd_addr  out  16  read address, bit 15 always 0
rd_valid  in  1  read data valid pulse
rd_data  in  8  read data
wr_en  out  1  register write strobe
wr_addr  out  16  write address, bit 15 always 0
wr_data  out  8  write data
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky read-timeout flag, cleared by txn_start

Behaviour:
- Reset is asynchronous and active-high. Reset values: every output is 0, the state is IDLE, and addr is 0.
- Header format: byte0 = {rw, addr[14:8]}, byte1 = addr[7:0]. rw=1 means read, rw=0 means write. The internal addr register is 15 bits. rd_addr and wr_addr are {1'b0, addr}.
- States: IDLE, HDR_HI, HDR_LO, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE: on txn_start go to HDR_HI. rx_valid is ignored in IDLE.
- HDR_HI: on rx_valid, latch rw and addr[14:8], then go to HDR_LO.
- HDR_LO: on rx_valid, latch addr[7:0]. If rw=0 go to WRITE. If rw=1 go to RD_ISSUE.
- WRITE: each rx_valid causes wr_en to pulse for exactly one cycle on the next clock, with wr_addr = current addr and wr_data = rx_data. addr then increments. There is no backpressure. Back-to-back rx_valid on consecutive cycles produces consecutive wr_en pulses.
- RD_ISSUE: rd_en pulses for one cycle with rd_addr = addr. Clear the timeout counter, then go to RD_WAIT.
- RD_WAIT: on rd_valid, set tx_data = rd_data and tx_valid=1, then go to RD_HOLD.
  - rd_valid in the same cycle as the rd_en pulse must also be accepted (the responder may return in 1 cycle).
  - If the counter reaches READ_TIMEOUT: set tx_data=0x00, tx_valid=1, timeout_err=1, and go to RD_HOLD.
- RD_HOLD: tx_valid and tx_data are held until tx_ack. On tx_ack: tx_valid drops next cycle, addr increments, and the state goes to RD_ISSUE.
  - Net effect: exactly one bus read per consumed byte, plus the initial prefetch.
  - rx_valid during any read state is ignored (dummy host bytes).
- Address increment wraps from 0x7FFF to 0x0000. Per-address side effects (e.g. FIFO pops in the frame buffer window) are the responder's concern; the initiator always increments.
- txn_end in any state: return to IDLE next cycle and clear tx_valid.
  - An rd_valid arriving after abort is discarded.
  - A wr_en already scheduled for the same cycle still completes.
  - The prefetched but unconsumed read is not retried.
- txn_start in any non-IDLE state: abort as for txn_end, then go directly to HDR_HI.
- txn_start also clears timeout_err.
- If txn_start and txn_end arrive in the same cycle, txn_start wins.
- rd_en and wr_en are never asserted in the same cycle. At most one read is outstanding.

Test Plan:
- Write burst: txn_start, bytes 0x00 0x48 0xAA 0x55 0x21 -> wr_en pulses at 0x0048=0xAA, 0x0049=0x55, 0x004A=0x21. No rd_en.
- Read burst: txn_start, 0x80 0x00; responder returns 0x12, 0x34 with 3-cycle latency; two tx_acks -> rd_en at 0x0000, 0x0001, 0x0002. tx_data sequence is 0x12, 0x34.
- Wrap: read header 0xFF 0xFF, one tx_ack -> rd_addr 0x7FFF, then 0x0000. Bit 15 is never set.
- Timeout: READ_TIMEOUT=4, responder silent -> tx_data=0x00 and tx_valid=1 within 6 cycles of rd_en. timeout_err=1 until the next txn_start.
- Abort: txn_end while in RD_WAIT, then a late rd_valid=0x99 -> tx_valid stays 0 and the state returns to IDLE.
- Reset during RD_HOLD (async, mid-cycle) -> all outputs read 0 before the next clock edge, and busy=0.
